// File: rtl/cnn_mac_requant.sv
// Streaming MAC: bias-seeded sum of NUM_TERMS signed products, rounded and saturated to OUT_WIDTH.
// Optional build macro CNN_REQUANT_RELU_EN clamps negative results to zero.
module cnn_mac_requant #(
    parameter int PROD_WIDTH = 29,
    parameter int ACC_WIDTH  = 34,
    parameter int OUT_WIDTH  = 16,
    parameter int SHIFT      = 10,
    parameter int NUM_TERMS  = 25
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic signed [PROD_WIDTH-1:0] in_prod,
    input  logic signed [OUT_WIDTH-1:0]  in_bias,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic signed [OUT_WIDTH-1:0]  out_data,
    output logic                         out_sat,
    output logic                         out_valid,
    input  logic                         out_ready
);

    localparam int CNT_W = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;

    localparam logic signed [ACC_WIDTH:0] SAT_MAX =
        {{(ACC_WIDTH + 2 - OUT_WIDTH){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] SAT_MIN = ~SAT_MAX;
    localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        ROUND = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                       r_state;
    state_t                       w_next_state;
    logic [CNT_W-1:0]             r_cnt;
    logic signed [ACC_WIDTH-1:0]  r_acc;
    logic                         r_in_ready;
    logic [OUT_WIDTH-1:0]         r_out_data;
    logic                         r_out_sat;
    logic                         r_out_valid;

    logic                         w_accept;
    logic                         w_last;
    logic signed [ACC_WIDTH-1:0]  w_prod_ext;
    logic signed [ACC_WIDTH-1:0]  w_bias_ext;
    logic signed [ACC_WIDTH-1:0]  w_seed;
    logic signed [ACC_WIDTH:0]    w_acc_x;
    logic signed [ACC_WIDTH:0]    w_r;
    logic [OUT_WIDTH-1:0]         w_res;
    logic                         w_sat;

    // in_ready is registered and only ever high in ACCUM, so it alone gates accepts
    assign w_accept   = in_valid & r_in_ready;
    assign w_last     = (r_cnt == CNT_W'(NUM_TERMS - 1));
    assign w_prod_ext = ACC_WIDTH'(in_prod);
    assign w_bias_ext = ACC_WIDTH'(in_bias);
    assign w_seed     = w_bias_ext <<< SHIFT;
    assign w_acc_x    = (ACC_WIDTH + 1)'(r_acc);

    // One guard bit keeps the rounding add from wrapping near the top of the accumulator
    generate
        if (SHIFT > 0) begin : g_round
            localparam logic signed [ACC_WIDTH:0] RND = {{ACC_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
            assign w_r = (w_acc_x + RND) >>> SHIFT;
        end else begin : g_noround
            assign w_r = w_acc_x;
        end
    endgenerate

    always_comb begin
        w_res = w_r[OUT_WIDTH-1:0];
        w_sat = 1'b0;
        if (w_r > SAT_MAX) begin
            w_res = OUT_MAX;
            w_sat = 1'b1;
        end else if (w_r < SAT_MIN) begin
            w_res = OUT_MIN;
            w_sat = 1'b1;
        end
`ifdef CNN_REQUANT_RELU_EN
        if (w_r[ACC_WIDTH]) begin
            w_res = '0;
            w_sat = 1'b0;
        end
`endif
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ACCUM:   if (w_accept && w_last) w_next_state = ROUND;
            ROUND:   w_next_state = HOLD;
            HOLD:    if (out_ready) w_next_state = ACCUM;
            default: w_next_state = ACCUM;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) r_state <= ACCUM;
        else           r_state <= w_next_state;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_cnt       <= '0;
            r_acc       <= '0;
            r_in_ready  <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_in_ready <= (w_next_state == ACCUM);
            if (w_accept) begin
                r_acc <= (r_cnt == '0) ? (w_seed + w_prod_ext) : (r_acc + w_prod_ext);
                r_cnt <= w_last ? '0 : (r_cnt + CNT_W'(1));
            end
            if (r_state == ROUND) begin
                r_out_data  <= w_res;
                r_out_sat   <= w_sat;
                r_out_valid <= 1'b1;
            end else if (r_state == HOLD && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_cnn_mac_requant.sv
// Directed bench for cnn_mac_requant: reset, sums, rounding, saturation, backpressure, mid-burst reset.
module tb_cnn_mac_requant;

    localparam int NT = 25;

    logic               ap_clk;
    logic               ap_rst_n;
    logic signed [28:0] in_prod;
    logic signed [15:0] in_bias;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] out_data;
    logic               out_sat;
    logic               out_valid;
    logic               out_ready;

    int n_tests;
    int n_fail;

    cnn_mac_requant #(
        .PROD_WIDTH(29),
        .ACC_WIDTH (34),
        .OUT_WIDTH (16),
        .SHIFT     (10),
        .NUM_TERMS (NT)
    ) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .in_prod  (in_prod),
        .in_bias  (in_bias),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_sat  (out_sat),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!in_ready && k < 50) begin
            tick();
            k++;
        end
        if (!in_ready) check("ready_timeout", 0, 1);
    endtask

    // Sends one burst (first product p0, the rest prest), leaves the bench sampling in HOLD
    task automatic run_burst(input int p0, input int prest, input int bias, input logic rdy);
        out_ready = rdy;
        for (int i = 0; i < NT; i++) begin
            wait_ready();
            in_valid = 1'b1;
            in_prod  = (i == 0) ? 29'(p0) : 29'(prest);
            in_bias  = (i == 0) ? 16'(bias) : 16'sh1234;
            tick();
        end
        in_valid = 1'b0;
        check("lat_round_valid", int'(out_valid), 0);
        check("lat_round_ready", int'(in_ready), 0);
        tick();
        check("lat_hold_valid", int'(out_valid), 1);
    endtask

    task automatic finish_xfer();
        out_ready = 1'b1;
        tick();
        check("xfer_valid_clr", int'(out_valid), 0);
        check("xfer_ready_set", int'(in_ready), 1);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        ap_rst_n  = 1'b0;
        in_valid  = 1'b1;
        in_prod   = 29'sd1024;
        in_bias   = '0;
        out_ready = 1'b0;

        repeat (3) tick();
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_sat", int'(out_sat), 0);
        ap_rst_n = 1'b1;
        in_valid = 1'b0;
        #1;
        check("rel_ready_pre", int'(in_ready), 0);
        tick();
        check("rel_ready_post", int'(in_ready), 1);

        run_burst(1024, 1024, 0, 1'b1);
        check("basic_data", int'(out_data), 25);
        check("basic_sat", int'(out_sat), 0);
        finish_xfer();

        run_burst(1024, 1024, 3, 1'b1);
        check("bias_data", int'(out_data), 28);
        finish_xfer();

        run_burst(1536, 0, 0, 1'b1);
        check("rnd_pos", int'(out_data), 2);
        finish_xfer();
        run_burst(-1536, 0, 0, 1'b1);
        check("rnd_neg", int'(out_data), -1);
        finish_xfer();
        run_burst(511, 0, 0, 1'b1);
        check("rnd_511", int'(out_data), 0);
        finish_xfer();

        run_burst(1 << 27, 1 << 27, 0, 1'b1);
        check("sat_pos_data", int'(out_data), 32767);
        check("sat_pos_flag", int'(out_sat), 1);
        finish_xfer();

        run_burst(-(1 << 27), -(1 << 27), 0, 1'b1);
`ifdef CNN_REQUANT_RELU_EN
        check("sat_neg_data", int'(out_data), 0);
        check("sat_neg_flag", int'(out_sat), 0);
`else
        check("sat_neg_data", int'(out_data), -32768);
        check("sat_neg_flag", int'(out_sat), 1);
`endif
        finish_xfer();

        // Backpressure: hold 5 cycles while poking in_valid with a large product
        run_burst(1024, 1024, 0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_prod  = 29'sd100000;
            tick();
            check("bp_valid", int'(out_valid), 1);
            check("bp_data", int'(out_data), 25);
            check("bp_ready", int'(in_ready), 0);
        end
        in_valid = 1'b0;
        finish_xfer();
        run_burst(1024, 1024, 0, 1'b1);
        check("bp_next_data", int'(out_data), 25);
        finish_xfer();

        // Mid-burst reset discards the partial sum
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wait_ready();
            in_valid = 1'b1;
            in_prod  = 29'sd1024;
            in_bias  = '0;
            tick();
        end
        in_valid = 1'b0;
        ap_rst_n = 1'b0;
        #1;
        check("mid_rst_ready", int'(in_ready), 0);
        tick();
        ap_rst_n = 1'b1;
        run_burst(1024, 1024, 0, 1'b1);
        check("mid_rst_data", int'(out_data), 25);
        finish_xfer();

        // Reset while holding a result drops it
        run_burst(1536, 0, 0, 1'b0);
        ap_rst_n = 1'b0;
        #1;
        check("hold_rst_valid", int'(out_valid), 0);
        check("hold_rst_data", int'(out_data), 0);
        tick();
        ap_rst_n = 1'b1;
        run_burst(1024, 1024, 0, 1'b1);
        check("hold_rst_next", int'(out_data), 25);
        finish_xfer();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "bench timeout");
    end

endmodule
